// File: rtl/rw_capture_replay.sv
// rw_capture_replay: alternating capture/replay buffer of DEPTH words.
// CAPTURE stores DEPTH consecutive input words; REPLAY emits them (forward or
// reversed) with a valid flag. __in1 advances the sequence; 0 stalls it.
// Handshake: there is no backpressure. __in1=1 means "step this cycle".
// __out0=1 marks the one cycle in which __out1 carries a freshly replayed word.
module rw_capture_replay #(
    parameter int W       = 3,
    parameter int DEPTH   = 4,
    parameter bit REVERSE = 1'b0,
    localparam int IW     = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  __in0,
    input  logic          __in1,
    output logic          __out0,
    output logic [W-1:0]  __out1,
    output logic          __out2,
    output logic [IW-1:0] __out3
);

    typedef enum logic {
        CAPTURE = 1'b0,
        REPLAY  = 1'b1
    } phase_t;

    localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);

    phase_t        phase_q;
    phase_t        phase_d;
    logic [IW-1:0] idx_q;
    logic [IW-1:0] idx_d;
    logic [W-1:0]  data_buf [DEPTH];
    logic          last_slot;
    logic [IW-1:0] rd_idx;

    // idx wraps only through this compare, so non-power-of-2 DEPTH never
    // lets idx reach values >= DEPTH.
    assign last_slot = (idx_q == LAST);
    assign rd_idx    = REVERSE ? (LAST - idx_q) : idx_q;

    // Next phase/slot: only advancing edges move the sequence.
    always_comb begin
        phase_d = phase_q;
        idx_d   = idx_q;
        if (__in1) begin
            if (last_slot) begin
                idx_d   = '0;
                phase_d = (phase_q == CAPTURE) ? REPLAY : CAPTURE;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    // Phase and slot index registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= CAPTURE;
            idx_q   <= '0;
        end else begin
            phase_q <= phase_d;
            idx_q   <= idx_d;
        end
    end

    // Buffer write during CAPTURE; reset clears so nothing stale is replayed.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_buf[i] <= '0;
            end
        end else if (__in1 && (phase_q == CAPTURE)) begin
            data_buf[idx_q] <= __in0;
        end
    end

    // Registered replay outputs; __out1 holds across stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            __out0 <= 1'b0;
            __out1 <= '0;
        end else if (__in1) begin
            if (phase_q == CAPTURE) begin
                __out0 <= 1'b0;
                __out1 <= '0;
            end else begin
                __out0 <= 1'b1;
                __out1 <= data_buf[rd_idx];
            end
        end else begin
            __out0 <= 1'b0;
        end
    end

    // Phase and index are already registers holding the post-update state.
    assign __out2 = (phase_q == REPLAY);
    assign __out3 = idx_q;

endmodule

// File: tb/tb_rw_capture_replay.sv
// tb_rw_capture_replay: three instances (forward D4/W3, reverse D4/W3,
// forward D3/W8) driven by shared stimulus. A step-count model checks every
// cycle; directed literal checks pin the model for each scenario.
module tb_rw_capture_replay;

  logic       clk;
  logic       rst;
  logic [7:0] in0;
  logic       in1;

  logic       f_v, r_v, t_v;
  logic [2:0] f_d, r_d;
  logic [7:0] t_d;
  logic       f_p, r_p, t_p;
  logic [1:0] f_x, r_x, t_x;

  int n_checks;
  int n_fail;
  bit model_ok;

  // ---------------- clock / reset block ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  rw_capture_replay #(.W(3), .DEPTH(4), .REVERSE(1'b0)) dut_f (
    .clk(clk), .rst(rst), .__in0(in0[2:0]), .__in1(in1),
    .__out0(f_v), .__out1(f_d), .__out2(f_p), .__out3(f_x)
  );

  rw_capture_replay #(.W(3), .DEPTH(4), .REVERSE(1'b1)) dut_r (
    .clk(clk), .rst(rst), .__in0(in0[2:0]), .__in1(in1),
    .__out0(r_v), .__out1(r_d), .__out2(r_p), .__out3(r_x)
  );

  rw_capture_replay #(.W(8), .DEPTH(3), .REVERSE(1'b0)) dut_t (
    .clk(clk), .rst(rst), .__in0(in0), .__in1(in1),
    .__out0(t_v), .__out1(t_d), .__out2(t_p), .__out3(t_x)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each instance is described by a count of advancing edges since reset.
  // Position within a round of 2*DEPTH steps decides capture vs replay.
  int         dp [3] = '{4, 4, 3};
  bit         rv [3] = '{1'b0, 1'b1, 1'b0};
  logic [7:0] wm [3] = '{8'h07, 8'h07, 8'hFF};
  int         m_s [3];
  logic [7:0] m_cap [3][4];
  logic       m_v [3];
  logic [7:0] m_d [3];
  int         pos, rr;
  logic       a_v;
  logic [7:0] a_d;
  logic       a_p;
  logic [1:0] a_x;

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_s[i] = 0;
        for (int j = 0; j < 4; j++) m_cap[i][j] = 8'h00;
        m_v[i] = 1'b0;
        m_d[i] = 8'h00;
      end else if (in1) begin
        pos = m_s[i] % (2 * dp[i]);
        if (pos < dp[i]) begin
          m_cap[i][pos] = in0 & wm[i];
          m_v[i] = 1'b0;
          m_d[i] = 8'h00;
        end else begin
          rr = pos - dp[i];
          m_v[i] = 1'b1;
          m_d[i] = m_cap[i][rv[i] ? (dp[i] - 1 - rr) : rr];
        end
        m_s[i] = m_s[i] + 1;
      end else begin
        m_v[i] = 1'b0;
      end
    end
    if (rst) model_ok = 1'b1;
    #1;
    // scoreboard compare, one pass per cycle once reset has been seen
    if (model_ok) begin
      for (int i = 0; i < 3; i++) begin
        case (i)
          0: begin a_v = f_v; a_d = {5'd0, f_d}; a_p = f_p; a_x = f_x; end
          1: begin a_v = r_v; a_d = {5'd0, r_d}; a_p = r_p; a_x = r_x; end
          default: begin a_v = t_v; a_d = t_d; a_p = t_p; a_x = t_x; end
        endcase
        check($sformatf("model_valid[%0d]", i), a_v, m_v[i]);
        check($sformatf("model_data[%0d]", i), a_d, m_d[i]);
        check($sformatf("model_phase[%0d]", i), a_p, (m_s[i] % (2 * dp[i])) >= dp[i]);
        check($sformatf("model_idx[%0d]", i), a_x, m_s[i] % dp[i]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic [7:0] d, input logic adv);
    @(negedge clk);
    rst = 1'b0;
    in0 = d;
    in1 = adv;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    in1 = 1'b1;
    in0 = 8'h07;
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_f_v"}, f_v, 0);
    check({tag, "_f_d"}, f_d, 0);
    check({tag, "_f_p"}, f_p, 0);
    check({tag, "_f_x"}, f_x, 0);
    check({tag, "_t_v"}, t_v, 0);
    check({tag, "_t_d"}, t_d, 0);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    model_ok = 1'b0;
    rst = 1'b1;
    in1 = 1'b1;
    in0 = 8'h07;

    // Reset held two cycles with advance and data active.
    do_reset(2);
    check_all_zero("reset");

    // Forward round 1,2,3,4; reverse instance sees 4,3,2,1.
    for (int k = 0; k < 4; k++) begin
      step(8'(k + 1), 1'b1);
      check("fwd_cap_valid", f_v, 0);
    end
    check("fwd_phase_replay", f_p, 1);
    for (int k = 0; k < 4; k++) begin
      step(8'h00, 1'b1);
      check("fwd_rep_valid", f_v, 1);
      check("fwd_rep_data", f_d, k + 1);
      check("rev_rep_data", r_d, 4 - k);
    end
    check("fwd_phase_back", f_p, 0);
    check("fwd_idx_back", f_x, 0);
    step(8'h00, 1'b1);
    check("fwd_after_valid", f_v, 0);

    // Reverse round 5,6,7,0.
    do_reset(1);
    step(8'd5, 1'b1); step(8'd6, 1'b1); step(8'd7, 1'b1); step(8'd0, 1'b1);
    step(8'h00, 1'b1); check("rev_w0", r_d, 0); check("rev_v0", r_v, 1);
    step(8'h00, 1'b1); check("rev_w1", r_d, 7);
    step(8'h00, 1'b1); check("rev_w2", r_d, 6);
    step(8'h00, 1'b1); check("rev_w3", r_d, 5); check("rev_v3", r_v, 1);

    // Stall after the second replay word.
    do_reset(1);
    for (int k = 0; k < 4; k++) step(8'(k + 1), 1'b1);
    step(8'h00, 1'b1); check("stall_pre0", f_d, 1);
    step(8'h00, 1'b1); check("stall_pre1", f_d, 2);
    for (int k = 0; k < 3; k++) begin
      step(8'h05, 1'b0);
      check("stall_valid", f_v, 0);
      check("stall_hold", f_d, 2);
      check("stall_idx", f_x, 2);
      check("stall_phase", f_p, 1);
    end
    step(8'h00, 1'b1); check("resume0", f_d, 3); check("resume_v", f_v, 1);
    step(8'h00, 1'b1); check("resume1", f_d, 4);
    check("resume_phase", f_p, 0);

    // Reset in the middle of REPLAY, then a fresh round.
    do_reset(1);
    for (int k = 0; k < 4; k++) step(8'(k + 1), 1'b1);
    step(8'h00, 1'b1); check("mid_w0", f_d, 1);
    do_reset(1);
    check_all_zero("mid_reset");
    for (int k = 0; k < 4; k++) step(8'd6, 1'b1);
    for (int k = 0; k < 4; k++) begin
      step(8'h00, 1'b1);
      check("fresh_data", f_d, 6);
      check("fresh_valid", f_v, 1);
    end

    // DEPTH=3, W=8: two back-to-back rounds.
    do_reset(1);
    for (int k = 0; k < 12; k++) begin
      if (k < 3) step(8'hA1 + 8'(k), 1'b1);
      else if (k >= 6 && k < 9) step(8'hB1 + 8'(k - 6), 1'b1);
      else step(8'h00, 1'b1);
      check("d3_idx", t_x, (k + 1) % 3);
      if (k >= 3 && k < 6) check("d3_round1", t_d, 8'hA1 + (k - 3));
      if (k >= 9) check("d3_round2", t_d, 8'hB1 + (k - 9));
    end

    // ---------------- final report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
